// File: rtl/des_perm_pipe.sv
// Purpose: selectable DES bit permutation (P, IP, FP, mode 3) on a 64-bit word, with a sideband tag.
// Latency: STAGES cycles from a beat presented with in_valid&in_ready to the same beat on out_valid.
// Backpressure: adv = !out_valid | out_ready; all stages shift together on adv, otherwise all hold; in_ready = adv.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input handshake; in_mode (0=P, 1=IP, 2=FP, 3=P^-1 or bypass), in_data, in_tag
//   out_valid / out_ready    output handshake; out_data, out_tag, out_mode belong to the beat in the last stage
//
// Optional feature macro: DES_PERM_PINV_EN
//   defined   -> mode 3 applies the inverse P-box to data[31:0], upper half forced to 0
//   undefined -> mode 3 passes the 64-bit word through unchanged and no P^-1 wiring exists
//
// Bit numbering: DES bit 1 is the MSB of the active field (32 bits for P/P^-1, 64 bits for IP/FP).
// Output bit k takes input bit table[k].

module des_perm_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode
);

  // Index width for the stage array; at least one bit so STAGES=1 still elaborates.
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

  typedef struct packed {
    logic [63:0]      dat;
    logic [TAG_W-1:0] tag;
    logic [1:0]       mode;
  } beat_t;

  // ---------------------------------------------------------------------------
  // Permutation tables, DES numbering (entry k-1 is the source of output bit k)
  // ---------------------------------------------------------------------------
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

`ifdef DES_PERM_PINV_EN
  localparam int PINV_T [32] = '{
     9, 17, 23, 31, 13, 28,  2, 18,
    24, 16, 30,  6, 26, 20, 10,  1,
     8, 14, 25,  3,  4, 29, 11, 19,
    32, 12, 22,  7,  5, 27, 15, 21
  };
`endif

  // ---------------------------------------------------------------------------
  // Permutation wiring (no logic, just bit routing)
  // ---------------------------------------------------------------------------
  logic [31:0] p_src;
  logic [31:0] p_w;
  logic [63:0] ip_w;
  logic [63:0] fp_w;

  assign p_src = in_data[31:0];

  // DES bit n of a W-bit field sits at vector index W-n.
  always_comb begin
    p_w  = '0;
    ip_w = '0;
    fp_w = '0;
    for (int k = 0; k < 32; k++) begin
      p_w[5'(31 - k)] = p_src[5'(32 - P_T[5'(k)])];
    end
    for (int k = 0; k < 64; k++) begin
      ip_w[6'(63 - k)] = in_data[6'(64 - IP_T[6'(k)])];
      fp_w[6'(63 - k)] = in_data[6'(64 - FP_T[6'(k)])];
    end
  end

`ifdef DES_PERM_PINV_EN
  logic [31:0] pinv_w;

  always_comb begin
    pinv_w = '0;
    for (int k = 0; k < 32; k++) begin
      pinv_w[5'(31 - k)] = p_src[5'(32 - PINV_T[5'(k)])];
    end
  end
`endif

  logic [63:0] perm_dat;

  always_comb begin
    perm_dat = in_data;
    case (in_mode)
      2'd0:    perm_dat = {32'h0, p_w};
      2'd1:    perm_dat = ip_w;
      2'd2:    perm_dat = fp_w;
      default: begin
`ifdef DES_PERM_PINV_EN
        perm_dat = {32'h0, pinv_w};
`else
        perm_dat = in_data;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline: one valid bit and one beat per stage, global advance
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  beat_t             stg_q [STAGES];
  beat_t             stg_d [STAGES];
  beat_t             in_beat;
  logic              adv;

  assign in_beat = '{dat: perm_dat, tag: in_tag, mode: in_mode};

  // Advance whenever the last stage is empty or being drained. Internal bubbles
  // are deliberately not squeezed out, so a stall freezes the whole pipe and
  // in_ready never depends on in_valid.
  assign adv = !vld_q[LAST] || out_ready;

  always_comb begin
    vld_d = vld_q;
    stg_d = stg_q;
    if (adv) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        vld_d[SW'(i)] = vld_q[SW'(i - 1)];
        stg_d[SW'(i)] = stg_q[SW'(i - 1)];
      end
      // in_ready equals adv here, so in_valid alone qualifies the load.
      // Bubbles carry zero payload so an idle output reads back as zero.
      vld_d[0] = in_valid;
      stg_d[0] = in_valid ? in_beat : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      stg_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign out_data  = stg_q[LAST].dat;
  assign out_tag   = stg_q[LAST].tag;
  assign out_mode  = stg_q[LAST].mode;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Purpose: randomized and directed bench for des_perm_pipe against a table-level reference model.
// Latency: checks exact STAGES latency (plus stall cycles) for every beat; STAGES=1/3 copies checked directly.
// Backpressure: random and directed out_ready stalls; output stability and in_ready rule checked every cycle.

module tb_des_perm_pipe;

  localparam int TAG_W  = 4;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [1:0]       in_mode = 2'd0;
  logic [63:0]      in_data = 64'h0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready, out_valid;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_mode;

  logic             a1_in_ready, a1_out_valid, a3_in_ready, a3_out_valid;
  logic [63:0]      a1_out_data, a3_out_data;
  logic [TAG_W-1:0] a1_out_tag, a3_out_tag;
  logic [1:0]       a1_out_mode, a3_out_mode;

  always #5 clk = ~clk;

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_mode(out_mode));

  des_perm_pipe #(.STAGES(1), .TAG_W(TAG_W)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a1_in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag), .out_valid(a1_out_valid), .out_ready(1'b1),
    .out_data(a1_out_data), .out_tag(a1_out_tag), .out_mode(a1_out_mode));

  des_perm_pipe #(.STAGES(3), .TAG_W(TAG_W)) dut_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a3_in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag), .out_valid(a3_out_valid), .out_ready(1'b1),
    .out_data(a3_out_data), .out_tag(a3_out_tag), .out_mode(a3_out_mode));

  // Only P and IP are tabulated here; FP and P^-1 are derived as their inverses.
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic [1:0] m);
    logic [63:0] r;
    r = 64'h0;
    case (m)
      2'd0: for (int k = 1; k <= 32; k++) r |= ((x >> (32 - P_T[k-1])) & 64'd1) << (32 - k);
      2'd1: for (int k = 1; k <= 64; k++) r |= ((x >> (64 - IP_T[k-1])) & 64'd1) << (64 - k);
      2'd2: for (int j = 1; j <= 64; j++) r |= ((x >> (64 - j)) & 64'd1) << (64 - IP_T[j-1]);
      default: begin
`ifdef DES_PERM_PINV_EN
        for (int j = 1; j <= 32; j++) r |= ((x >> (32 - j)) & 64'd1) << (32 - P_T[j-1]);
`else
        r = x;
`endif
      end
    endcase
    return r;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor (samples on negedge) ----------------
  typedef struct {
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
    logic [1:0]       m;
    int               c;
    int               s;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               stall_cnt = 0;
  int               out_cnt = 0;
  bit               was_stall = 0;
  logic [63:0]      held_d;
  logic [TAG_W-1:0] held_t;
  logic [1:0]       held_m;
  bit               vin_h [4096];
  bit               vout_h [4096];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc < 4096) begin
        vin_h[cyc]  = in_valid && in_ready;
        vout_h[cyc] = out_valid;
      end
      if (rst) begin
        sb.delete();
        was_stall = 0;
      end else begin
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (was_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_data, held_d);
          chk("stall_tag", 64'(out_tag), 64'(held_t));
          chk("stall_mode", 64'(out_mode), 64'(held_m));
        end
        if (out_valid && out_ready) begin
          out_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_out", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_tag", 64'(out_tag), 64'(e.t));
            chk("out_mode", 64'(out_mode), 64'(e.m));
            chk("latency", 64'(cyc - e.c), 64'(STAGES + stall_cnt - e.s));
          end
        end
        if (out_valid && !out_ready) begin
          stall_cnt++;
          was_stall = 1;
          held_d = out_data;
          held_t = out_tag;
          held_m = out_mode;
        end else begin
          was_stall = 0;
        end
        if (in_valid && in_ready)
          sb.push_back('{ref_perm(in_data, in_mode), in_tag, in_mode, cyc, stall_cnt});
      end
      cyc++;
    end
  end

  // ---------------- drivers (all return at posedge+1) ----------------
  task automatic drive(input logic [63:0] d, input logic [1:0] m, input logic [TAG_W-1:0] t);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [63:0] d, input logic [1:0] m, output logic [63:0] r);
    int w;
    w = 0;
    drive(d, m, TAG_W'($urandom));
    in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("xfer_valid", 64'(out_valid), 64'd1);
    r = out_data;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] x, y, z;
  int          c0, snap;
  bit          done;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_mode", 64'(out_mode), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // P single bits and upper-half masking
    xfer(64'h1, 2'd0, y);                  chk("p_bit32", y, 64'h0000_0000_0000_0800);
    xfer(64'h8000_0000, 2'd0, y);          chk("p_bit1", y, 64'h0000_0000_0080_0000);
    xfer(64'hFFFF_FFFF_0000_0000, 2'd0, y); chk("p_upper_ignored", y, 64'h0);

    // IP / FP known vectors
    xfer(64'h1, 2'd1, y);                  chk("ip_bit64", y, 64'h0000_0080_0000_0000);
    xfer(y, 2'd2, z);                      chk("fp_back", z, 64'h1);

    // Mode 3
`ifdef DES_PERM_PINV_EN
    xfer(64'hDEAD_BEEF, 2'd0, y);
    xfer(y, 2'd3, z);                      chk("pinv_roundtrip", z, 64'hDEAD_BEEF);
`else
    xfer(64'h0123_4567_89AB_CDEF, 2'd3, y); chk("mode3_bypass", y, 64'h0123_4567_89AB_CDEF);
`endif

    // STAGES=1 and STAGES=3 latency (those copies always have out_ready=1)
    idle(5);
    x = {$urandom, $urandom};
    in_valid = 1'b1; in_data = x; in_mode = 2'd1; in_tag = 4'h5;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("s1_valid_at_1", 64'(a1_out_valid), 64'd1);
    chk("s1_data", a1_out_data, ref_perm(x, 2'd1));
    chk("s1_tag", 64'(a1_out_tag), 64'h5);
    chk("s3_idle_at_1", 64'(a3_out_valid), 64'd0);
    @(negedge clk);
    chk("s1_idle_at_2", 64'(a1_out_valid), 64'd0);
    chk("s3_idle_at_2", 64'(a3_out_valid), 64'd0);
    @(negedge clk);
    chk("s3_valid_at_3", 64'(a3_out_valid), 64'd1);
    chk("s3_data", a3_out_data, ref_perm(x, 2'd1));
    @(posedge clk);
    #1;

    // 100 random IP/FP round trips
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom};
      xfer(x, 2'd1, y);
      xfer(y, 2'd2, z);
      chk("ip_fp_roundtrip", z, x);
    end

    // 8 back-to-back beats with a 3-cycle stall mid-stream
    idle(2);
    snap = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) drive({$urandom, $urandom}, 2'(i % 4), TAG_W'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    chk("stall_count", 64'(out_cnt - snap), 64'd8);
    chk("stall_drain", 64'(sb.size()), 64'd0);

    // Alternating valid: output pattern is the input pattern delayed by STAGES
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive({$urandom, $urandom}, 2'($urandom), TAG_W'(i));
      else idle(1);
    end
    idle(4);
    for (int i = c0; i < c0 + 10; i++) chk("bubble_pattern", 64'(vout_h[i + STAGES]), 64'(vin_h[i]));

    // Continuous valid: one output per cycle
    c0 = cyc;
    for (int i = 0; i < 12; i++) drive({$urandom, $urandom}, 2'($urandom), TAG_W'(i));
    idle(4);
    for (int i = c0; i < c0 + 12; i++) chk("throughput", 64'(vout_h[i + STAGES]), 64'd1);

    // Reset with two beats in flight
    drive(64'hAAAA_5555_1234_5678, 2'd1, 4'hA);
    drive(64'h5555_AAAA_8765_4321, 2'd2, 4'hB);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    snap = out_cnt;
    @(posedge clk);
    #1;
    idle(6);
    chk("midrst_no_old_beats", 64'(out_cnt - snap), 64'd0);

    // Random stream with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          drive({$urandom, $urandom}, 2'($urandom), TAG_W'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised, pipelined successor of the fixed 32-bit DES P-box.
- One 64-bit datapath that applies a per-transaction selected DES bit permutation: P, IP or IP^-1 (FP).
- Carries a sideband tag through the pipe and uses valid/ready handshakes on both sides.
- Sits between the round-function/S-box stage and the round/output logic, so all DES permutations can share one timed, back-pressurable unit.

Parameters:
- STAGES, 2, number of register stages (1..3); input-to-output latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside the data (1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_mode  input  2  permutation select, sampled with the beat: 0=P, 1=IP, 2=FP, 3=see Optional Feature.
- in_data  input  64  input word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  64  permuted word.
- out_tag  output  TAG_W  tag of the beat on out_data.
- out_mode  output  2  mode of the beat on out_data.

Behaviour:
- Clock and reset: single clock domain clk; rst is synchronous and active-high.
- Bit numbering: DES bit 1 is the MSB of the active field, for both input and output.
  - P mode: the active field is data[31:0]; out_data[63:32] is forced to 0 and in_data[63:32] is ignored.
  - IP and FP modes: the active field is all 64 bits.
- Tables:
  - P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
  - IP and FP are per FIPS 46-3.
  - Output bit k takes input bit table[k].
- Permutation is pure wiring into stage 1. Stages 2..STAGES are plain register copies.
- Pipeline control:
  - Each stage holds a valid bit plus data, tag and mode.
  - adv = !out_valid | out_ready.
  - When adv=1, every stage shifts forward by one; stage 1 loads the input beat when in_valid & in_ready, else loads a bubble (valid=0).
  - When adv=0, all stages hold.
  - in_ready = adv (combinational from out_valid and out_ready).
- Latency: a beat accepted at edge N appears on out_valid at edge N+STAGES, if no stall occurs.
- Throughput: one beat per cycle while out_ready=1.
- Stall: if out_ready=0 while out_valid=1, out_data, out_tag and out_mode stay stable and in_ready=0 until the beat is taken.
- Bubbles do not collapse while stalled.
- Transfer rule: out_valid & out_ready transfers in the same cycle that new data shifts in. No loss, no duplication.
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - out_data=0, out_tag=0, out_mode=0.
  - in_ready=1 in the first cycle after reset.
  - Beats in flight when rst asserts are discarded.
- in_ready ignores in_valid (no combinational loop on the input side).
- Mode 3 without the optional feature is bypass: out_data = in_data, unmodified.

Optional Feature:
- Macro: DES_PERM_PINV_EN.
- Defined: mode 3 applies the inverse P-box P^-1 on data[31:0], with out_data[63:32]=0.
  - P^-1 = 9 17 23 31 13 28 2 18 24 16 30 6 26 20 10 1 8 14 25 3 4 29 11 19 32 12 22 7 5 27 15 21.
- Undefined: mode 3 is 64-bit bypass and no P^-1 logic is synthesised.

Test Plan:
- P single bits, STAGES=2, out_ready=1:
  - in_data=64'h1, mode 0 -> out_data=64'h0000_0000_0000_0800 exactly 2 cycles later.
  - in_data=64'h8000_0000 -> out_data=64'h0000_0000_0080_0000.
  - in_data=64'hFFFF_FFFF_0000_0000 -> out_data=0.
- IP/FP round trip:
  - in_data=64'h1, mode 1 -> out_data=64'h0000_0080_0000_0000.
  - Feeding that value back with mode 2 -> out_data=64'h1.
  - 100 random words: FP(IP(x))==x.
- Back-to-back with stall:
  - Stream 8 beats, tags 0..7, mixed modes; hold out_ready=0 for 3 cycles mid-stream.
  - Required: out_data/out_tag held stable, in_ready=0 during the stall, all 8 beats delivered in order, none dropped or duplicated.
- Bubbles and throughput:
  - Alternate in_valid 1/0 with out_ready=1 -> out_valid alternates with the same pattern, delayed by STAGES.
  - Continuous valid -> one output per cycle.
- Reset mid-operation:
  - Assert rst for 1 cycle while 2 beats are in flight -> out_valid=0, out_data=0 and in_ready=1 the next cycle; the old beats never appear.
- Mode 3:
  - With DES_PERM_PINV_EN: P^-1(P(x))==x for x=32'hDEAD_BEEF.
  - Without it: in_data=64'h0123_4567_89AB_CDEF -> out_data=64'h0123_4567_89AB_CDEF.
  - Repeat with STAGES=1 and STAGES=3 and confirm latency.
